// File: rtl/claw_axis_controller.sv
// claw_axis_controller: per-axis stepper sequencer for the claw game.
// Turns debounced direction buttons and the home limit switch into
// enable/direction/step-strobe for the phase driver. It also keeps an
// absolute step position with homing, soft travel limits and a fault state.
module claw_axis_controller #(
  parameter int unsigned CLK_DIV  = 100000,
  parameter int unsigned MAX_POS  = 2000,
  parameter int unsigned HOME_MAX = 4095,
  parameter int unsigned POS_W    = 12,
  parameter logic        HOME_DIR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_fwd,
  input  logic             btn_rev,
  input  logic             home_req,
  input  logic             limit_home,
  output logic             motor_en,
  output logic             motor_dir,
  output logic             step_strobe,
  output logic [POS_W-1:0] position,
  output logic             homed,
  output logic             fault,
  output logic [2:0]       led
);

  localparam int unsigned      CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] HOME_LAST = POS_W'(HOME_MAX - 1);

  typedef enum logic [2:0] {
    S_HOMING,
    S_IDLE,
    S_MOVE_FWD,
    S_MOVE_REV,
    S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] presc;
  logic [POS_W-1:0] home_cnt;
  logic             tick;

  assign tick = (presc == CNT_LAST);
  assign led  = {fault, motor_en, homed};

  // Free-running step-rate prescaler; tick marks the last count of each period.
  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

  // Axis sequencer. Outputs are registered alongside the next state, so every
  // transition also loads the enable/direction that belong to the new state.
  // Exit conditions are tested before the tick, so an exiting cycle never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOMING;
      home_cnt    <= '0;
      position    <= '0;
      homed       <= 1'b0;
      fault       <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= HOME_DIR;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      case (state)
        S_HOMING: begin
          motor_en  <= 1'b1;
          motor_dir <= HOME_DIR;
          if (limit_home) begin
            position <= '0;
            homed    <= 1'b1;
            motor_en <= 1'b0;
            state    <= S_IDLE;
          end else if (tick) begin
            step_strobe <= 1'b1;
            home_cnt    <= home_cnt + 1'b1;
            // The step that exhausts the homing budget is still taken.
            if (home_cnt == HOME_LAST) begin
              homed    <= 1'b0;
              fault    <= 1'b1;
              motor_en <= 1'b0;
              state    <= S_FAULT;
            end
          end
        end

        S_IDLE: begin
          motor_en <= 1'b0;
          if (home_req) begin
            homed     <= 1'b0;
            home_cnt  <= '0;
            motor_en  <= 1'b1;
            motor_dir <= HOME_DIR;
            state     <= S_HOMING;
          end else if (btn_fwd && !btn_rev && homed && (position < POS_MAX)) begin
            motor_en  <= 1'b1;
            motor_dir <= ~HOME_DIR;
            state     <= S_MOVE_FWD;
          end else if (btn_rev && !btn_fwd && homed && (position != '0)) begin
            motor_en  <= 1'b1;
            motor_dir <= HOME_DIR;
            state     <= S_MOVE_REV;
          end
        end

        S_MOVE_FWD: begin
          if (limit_home) begin
            // Hitting home while moving away from it is a mechanical fault.
            homed    <= 1'b0;
            fault    <= 1'b1;
            motor_en <= 1'b0;
            state    <= S_FAULT;
          end else if (!btn_fwd || btn_rev) begin
            motor_en <= 1'b0;
            state    <= S_IDLE;
          end else if (tick) begin
            if (position < POS_MAX) begin
              step_strobe <= 1'b1;
              position    <= position + 1'b1;
            end else begin
              motor_en <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        S_MOVE_REV: begin
          if (limit_home) begin
            position <= '0;
            motor_en <= 1'b0;
            state    <= S_IDLE;
          end else if (!btn_rev || btn_fwd) begin
            motor_en <= 1'b0;
            state    <= S_IDLE;
          end else if (tick) begin
            if (position != '0) begin
              step_strobe <= 1'b1;
              position    <= position - 1'b1;
            end else begin
              motor_en <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        S_FAULT: begin
          motor_en <= 1'b0;
          fault    <= 1'b1;
          if (home_req) begin
            fault     <= 1'b0;
            home_cnt  <= '0;
            motor_en  <= 1'b1;
            motor_dir <= HOME_DIR;
            state     <= S_HOMING;
          end
        end

        default: begin
          homed    <= 1'b0;
          fault    <= 1'b1;
          motor_en <= 1'b0;
          state    <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_claw_axis_controller.sv
// Testbench for claw_axis_controller: directed test-plan steps followed by a
// randomized phase, all compared each cycle against a behavioural axis model.
module tb_claw_axis_controller;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned MAX_POS  = 10;
  localparam int unsigned HOME_MAX = 20;
  localparam int unsigned POS_W    = 12;
  localparam logic        HOME_DIR = 1'b0;

  logic             clk = 1'b0;
  logic             rst, btn_fwd, btn_rev, home_req, limit_home;
  logic             motor_en, motor_dir, step_strobe, homed, fault;
  logic [POS_W-1:0] position;
  logic [2:0]       led;

  claw_axis_controller #(
    .CLK_DIV (CLK_DIV),
    .MAX_POS (MAX_POS),
    .HOME_MAX(HOME_MAX),
    .POS_W   (POS_W),
    .HOME_DIR(HOME_DIR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_fwd    (btn_fwd),
    .btn_rev    (btn_rev),
    .home_req   (home_req),
    .limit_home (limit_home),
    .motor_en   (motor_en),
    .motor_dir  (motor_dir),
    .step_strobe(step_strobe),
    .position   (position),
    .homed      (homed),
    .fault      (fault),
    .led        (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the axis: what it is doing, where it is, what it knows.
  typedef enum {M_HOME, M_IDLE, M_FWD, M_REV, M_FAULT} mode_t;
  mode_t m_mode;
  int    m_pos, m_hcnt, m_cyc;
  bit    m_homed, m_en, m_dir, m_strobe;

  int tcyc = 0, nstrobe = 0, last_strobe = -1, gap = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit tick;
    m_strobe = 1'b0;
    if (rst) begin
      m_mode  = M_HOME;
      m_pos   = 0;
      m_homed = 1'b0;
      m_hcnt  = 0;
      m_cyc   = 0;
      m_dir   = HOME_DIR;
      m_en    = 1'b0;
    end else begin
      tick  = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
      m_cyc = m_cyc + 1;
      case (m_mode)
        M_HOME:
          if (limit_home) begin
            m_pos = 0; m_homed = 1'b1; m_mode = M_IDLE;
          end else if (tick) begin
            m_strobe = 1'b1;
            m_hcnt   = m_hcnt + 1;
            if (m_hcnt >= HOME_MAX) m_mode = M_FAULT;
          end
        M_IDLE:
          if (home_req) begin
            m_homed = 1'b0; m_hcnt = 0; m_mode = M_HOME;
          end else if (btn_fwd && !btn_rev && m_homed && m_pos < MAX_POS) m_mode = M_FWD;
          else if (btn_rev && !btn_fwd && m_homed && m_pos > 0) m_mode = M_REV;
        M_FWD:
          if (limit_home) begin
            m_homed = 1'b0; m_mode = M_FAULT;
          end else if (!btn_fwd || btn_rev) m_mode = M_IDLE;
          else if (tick) begin
            if (m_pos < MAX_POS) begin m_pos = m_pos + 1; m_strobe = 1'b1; end
            else m_mode = M_IDLE;
          end
        M_REV:
          if (limit_home) begin
            m_pos = 0; m_mode = M_IDLE;
          end else if (!btn_rev || btn_fwd) m_mode = M_IDLE;
          else if (tick) begin
            if (m_pos > 0) begin m_pos = m_pos - 1; m_strobe = 1'b1; end
            else m_mode = M_IDLE;
          end
        M_FAULT:
          if (home_req) begin
            m_hcnt = 0; m_mode = M_HOME;
          end
        default: m_mode = M_FAULT;
      endcase
      m_en = (m_mode == M_HOME) || (m_mode == M_FWD) || (m_mode == M_REV);
      if (m_mode == M_FWD) m_dir = ~HOME_DIR;
      else if (m_mode == M_HOME || m_mode == M_REV) m_dir = HOME_DIR;
    end
  endtask

  // One clock: update the model, let the edge happen, then compare outputs.
  task automatic step();
    bit m_fault;
    model_edge();
    @(posedge clk);
    #1;
    tcyc++;
    if (rst) last_strobe = -1;
    if (step_strobe) begin
      nstrobe++;
      gap = (last_strobe >= 0) ? (tcyc - last_strobe) : -1;
      if (gap >= 0) check("strobe_spacing", 32'(gap >= int'(CLK_DIV)), 32'd1);
      last_strobe = tcyc;
    end
    m_fault = (m_mode == M_FAULT) && !rst;
    check("position", 32'(position), 32'(m_pos));
    check("outputs", 32'({motor_en, motor_dir, step_strobe, homed, fault, led}),
          32'({m_en, m_dir, m_strobe, m_homed, m_fault, m_fault, m_en, m_homed}));
  endtask

  // Drive the axis from IDLE to a target position, then release the buttons.
  task automatic goto_pos(input int target);
    int n = 0;
    if (m_pos < target) btn_fwd = 1'b1;
    else if (m_pos > target) btn_rev = 1'b1;
    while (m_pos != target && n < 200) begin
      step();
      n++;
    end
    check("goto_reached", 32'(position), 32'(target));
    btn_fwd = 1'b0;
    btn_rev = 1'b0;
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; btn_fwd = 1'b0; btn_rev = 1'b0; home_req = 1'b0; limit_home = 1'b0;
    step();
    step();
    check("rst_vals", 32'({motor_en, motor_dir, step_strobe, homed, fault, led}), 32'd0);
    check("rst_pos", 32'(position), 32'd0);

    // Homing: 5 ticks without the switch, then the switch closes.
    rst = 1'b0;
    nstrobe = 0;
    step();
    check("first_cycle_en", 32'(motor_en), 32'd1);
    for (int i = 0; i < 19; i++) step();
    check("homing_strobes", 32'(nstrobe), 32'd5);
    limit_home = 1'b1;
    step();
    limit_home = 1'b0;
    check("homed_state", 32'({motor_en, homed, position}), 32'({1'b0, 1'b1, 12'd0}));

    // Forward soft limit.
    btn_fwd = 1'b1;
    nstrobe = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (step_strobe && nstrobe > 1) check("fwd_gap", 32'(gap), 32'(CLK_DIV));
    end
    check("fwd_strobes", 32'(nstrobe), 32'(MAX_POS));
    check("fwd_pos", 32'(position), 32'(MAX_POS));
    check("fwd_en_drop", 32'(motor_en), 32'd0);
    btn_fwd = 1'b0;
    step();

    // Three reverse ticks, then release.
    btn_rev = 1'b1;
    nstrobe = 0;
    n = 0;
    while (nstrobe < 3 && n < 40) begin step(); n++; end
    btn_rev = 1'b0;
    step();
    check("rev_pos", 32'(position), 32'd7);
    check("rev_en_drop", 32'(motor_en), 32'd0);

    // Both buttons together do nothing.
    btn_fwd = 1'b1; btn_rev = 1'b1;
    nstrobe = 0;
    for (int i = 0; i < 12; i++) step();
    check("both_strobes", 32'(nstrobe), 32'd0);
    check("both_en", 32'(motor_en), 32'd0);

    // home_req while moving forward is ignored.
    btn_rev = 1'b0;
    step(); step(); step();
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    step();
    check("hreq_in_fwd", 32'({motor_en, homed, fault}), 32'b110);
    btn_fwd = 1'b0;
    step();

    // Limit switch while moving away from home at position 4.
    goto_pos(4);
    btn_fwd = 1'b1;
    step();
    limit_home = 1'b1;
    step();
    limit_home = 1'b0; btn_fwd = 1'b0;
    check("fwd_limit_fault", 32'({fault, homed, led}), 32'({1'b1, 1'b0, 3'b100}));
    check("fwd_limit_pos", 32'(position), 32'd4);
    step();
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    check("fault_exit", 32'({fault, motor_en}), 32'b01);
    limit_home = 1'b1;
    step();
    limit_home = 1'b0;

    // Limit switch while reversing at position 6 resynchronises to home.
    goto_pos(6);
    btn_rev = 1'b1;
    step();
    limit_home = 1'b1;
    step();
    limit_home = 1'b0; btn_rev = 1'b0;
    check("rev_limit", 32'({motor_en, homed, fault, position}), 32'({3'b010, 12'd0}));
    step();

    // Homing timeout.
    nstrobe = 0;
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    n = 0;
    while (!fault && n < 200) begin step(); n++; end
    check("timeout_strobes", 32'(nstrobe), 32'(HOME_MAX));
    check("timeout_led", 32'({led, motor_en}), 32'b1000);
    for (int i = 0; i < 6; i++) step();
    home_req = 1'b1;
    step();
    home_req = 1'b0;
    check("timeout_rehome", 32'({fault, motor_en, motor_dir}), 32'({2'b01, HOME_DIR}));
    limit_home = 1'b1;
    step();
    limit_home = 1'b0;

    // Reset in the middle of a forward move at position 5.
    btn_fwd = 1'b1;
    n = 0;
    while (m_pos < 5 && n < 100) begin step(); n++; end
    rst = 1'b1; btn_fwd = 1'b0;
    step();
    check("midrst", 32'({position, homed, step_strobe}), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_homing", 32'({motor_en, homed}), 32'b10);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) btn_fwd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) btn_rev = 1'($urandom_range(0, 1));
      home_req   = ($urandom_range(0, 39) == 0);
      limit_home = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/claw_axis_controller.md
# claw_axis_controller

Per-axis motion sequencer for the claw game. It sits directly upstream of each stepper phase driver. It consumes the debounced RF direction buttons and the axis home limit switch, and produces the enable, direction and per-step strobe the driver advances on. It also maintains an absolute step position with homing, soft travel limits and a fault state, so the claw cannot be driven past either end of its travel.

## Interface
Parameters:
- CLK_DIV, 100000: clk cycles per step tick (1 kHz at 100 MHz); must be ≥ 2.
- MAX_POS, 2000: soft travel limit in steps, measured from home.
- HOME_MAX, 4095: maximum steps allowed during homing before fault.
- POS_W, 12: position width; 2^POS_W must exceed max(MAX_POS, HOME_MAX).
- HOME_DIR, 0: motor_dir value that moves toward the home switch.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- btn_fwd  in  1  debounced level, request motion away from home.
- btn_rev  in  1  debounced level, request motion toward home.
- home_req  in  1  one-cycle pulse, start homing (honoured only in IDLE or FAULT).
- limit_home  in  1  debounced home limit switch, active-high.
- motor_en  out  1  driver enable.
- motor_dir  out  1  driver direction.
- step_strobe  out  1  one-cycle pulse per step taken.
- position  out  POS_W  absolute step count, 0 = home.
- homed  out  1  position is valid.
- fault  out  1  axis in FAULT.
- led  out  3  {fault, motor_en, homed}.

## Operation
- Prescaler: free-running counter 0..CLK_DIV-1. tick = (count == CLK_DIV-1). The counter clears on rst.
- States: HOMING, IDLE, MOVE_FWD, MOVE_REV, FAULT. rst forces HOMING.
- motor_en = 1 in HOMING, MOVE_FWD and MOVE_REV; 0 otherwise.
- motor_dir:
  - HOMING and MOVE_REV: HOME_DIR.
  - MOVE_FWD: ~HOME_DIR.
  - Otherwise: holds its last value.
- HOMING:
  - On each tick with limit_home=0: emit a strobe and increment the internal home step counter.
  - limit_home=1 on any cycle: position←0, homed←1, go to IDLE, no strobe.
  - Home step counter reaches HOME_MAX: go to FAULT, homed←0.
- IDLE:
  - home_req: clear homed, go to HOMING. home_req has priority over the buttons.
  - Else btn_fwd & ~btn_rev & homed & position<MAX_POS: go to MOVE_FWD.
  - Else btn_rev & ~btn_fwd & homed & position>0: go to MOVE_REV.
  - Both buttons high, or homed=0: stay in IDLE.
- MOVE_FWD:
  - On tick: if position<MAX_POS, strobe and position+1; else go to IDLE.
  - btn_fwd=0 or btn_rev=1: go to IDLE on that cycle.
  - limit_home=1 (switch hit while moving away from home, i.e. a mechanical fault): go to FAULT, homed←0.
- MOVE_REV:
  - On tick: if position>0, strobe and position−1; else go to IDLE.
  - limit_home=1: position←0 (resync to home), go to IDLE, no strobe.
  - btn_rev=0 or btn_fwd=1: go to IDLE.
- FAULT: motor stopped. home_req is the only exit, to HOMING; position holds.
- Exit checks (button release, limit) take priority over a tick in the same cycle: no strobe on an exiting cycle.
- Position never wraps. The 0 and MAX_POS bounds are enforced before the update.

## Timing
- All outputs are registered.
- Reset values: motor_en=0, motor_dir=HOME_DIR, step_strobe=0, position=0, homed=0, fault=0, led=3'b000, prescaler=0.
- First cycle after rst deasserts: state=HOMING, motor_en=1.
- A qualifying tick at edge N gives step_strobe=1 and the updated position, both visible after edge N, for exactly one cycle.
- Button press to motor_en=1: 1 cycle. Button release to motor_en=0: 1 cycle.
- limit_home high to motor_en=0 (or fault=1): 1 cycle.
- Step rate: at most one strobe per CLK_DIV cycles. Strobes never occur on consecutive cycles.
- rst mid-move: next edge aborts all motion, clears position and homed, and returns to HOMING.

## Test plan
(all with CLK_DIV=4, MAX_POS=10, HOME_MAX=20)
- Homing: release rst, hold limit_home=0 for 5 ticks, then 1 → 5 strobes, then motor_en=0, homed=1, position=0, state IDLE.
- Forward soft limit: homed, hold btn_fwd → exactly 10 strobes 4 cycles apart, position=10, motor_en drops, no 11th strobe. Then hold btn_rev 3 ticks and release → position=7.
- Conflicting and idle inputs: btn_fwd and btn_rev both high → motor_en stays 0, no strobes. home_req while in MOVE_FWD → ignored.
- Homing timeout: limit_home never asserts → 20 strobes, then fault=1, led=3'b100, motor_en=0. A home_req pulse restarts HOMING.
- Limit in MOVE_FWD at position 4 → fault=1, homed=0 one cycle later, position holds 4. In MOVE_REV at position 6, limit_home=1 → position=0, IDLE, homed stays 1.
- Reset mid-move: assert rst at position 5 during MOVE_FWD → next cycle position=0, homed=0, step_strobe=0. After release, state=HOMING.
